// File: rtl/regfile_operand_reader.sv
// Operand reader for the 32x64 bank: same-cycle write bypass, busy scoreboard, one-entry output buffer.
// Latency 1 cycle from accept; req_ready drops on a RAW hazard or when a held response is not taken.
module regfile_operand_reader #(
  parameter  int WIDTH    = 64,
  parameter  int NREGS    = 32,
  parameter  int ZERO_REG = 31,
  localparam int IW       = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NREGS-1:0][WIDTH-1:0]  regs_in,
  input  logic [NREGS-1:0]             wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [IW-1:0]                req_ra,
  input  logic [IW-1:0]                req_rb,
  input  logic [IW-1:0]                req_rd,
  input  logic                         req_rd_we,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [WIDTH-1:0]             rsp_a,
  output logic [WIDTH-1:0]             rsp_b,
  output logic [IW-1:0]                rsp_rd,
  output logic [NREGS-1:0]             busy
);

  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_a_q, rsp_a_d;
  logic [WIDTH-1:0]    rsp_b_q, rsp_b_d;
  logic [IW-1:0]       rsp_rd_q, rsp_rd_d;
  logic [NREGS-1:0]    busy_q, busy_d;
  logic [NREGS-1:0]    clr;
  logic [NREGS-1:0]    set;
  logic                hz;
  logic                accept;

  function automatic logic [WIDTH-1:0] sel_operand(
    input logic [IW-1:0]                idx,
    input logic [NREGS-1:0][WIDTH-1:0]  bank,
    input logic [NREGS-1:0]             wen,
    input logic [WIDTH-1:0]             wdat
  );
    if (idx == IW'(ZERO_REG))
      return '0;
    else if (wen[idx])
      return wdat;
    else
      return bank[idx];
  endfunction

  always_comb begin
    clr           = wr_en;
    clr[ZERO_REG] = 1'b0;

    // A write landing this cycle resolves the hazard; the bypass supplies its data.
    hz = (busy_q[req_ra] & ~clr[req_ra])
       | (busy_q[req_rb] & ~clr[req_rb])
       | (req_rd_we & busy_q[req_rd] & ~clr[req_rd]);

    req_ready = reset & ~hz & (~rsp_valid_q | rsp_ready);
    accept    = req_valid & req_ready;

    set = '0;
    if (accept && req_rd_we && (req_rd != IW'(ZERO_REG)))
      set[req_rd] = 1'b1;

    busy_d           = (busy_q & ~clr) | set;
    busy_d[ZERO_REG] = 1'b0;

    rsp_valid_d = rsp_valid_q;
    rsp_a_d     = rsp_a_q;
    rsp_b_d     = rsp_b_q;
    rsp_rd_d    = rsp_rd_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_a_d     = sel_operand(req_ra, regs_in, wr_en, wr_data);
      rsp_b_d     = sel_operand(req_rb, regs_in, wr_en, wr_data);
      rsp_rd_d    = req_rd;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_a_q     <= '0;
      rsp_b_q     <= '0;
      rsp_rd_q    <= '0;
      busy_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_a_q     <= rsp_a_d;
      rsp_b_q     <= rsp_b_d;
      rsp_rd_q    <= rsp_rd_d;
      busy_q      <= busy_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_a     = rsp_a_q;
  assign rsp_b     = rsp_b_q;
  assign rsp_rd    = rsp_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_operand_reader.sv
// Directed plus random bench for regfile_operand_reader against a behavioural register/scoreboard model.
module tb_regfile_operand_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic [31:0][63:0]     regs_in;
  logic [31:0]           wr_en;
  logic [63:0]           wr_data;
  logic                  req_valid, req_ready;
  logic [4:0]            req_ra, req_rb, req_rd;
  logic                  req_rd_we;
  logic                  rsp_valid, rsp_ready;
  logic [63:0]           rsp_a, rsp_b;
  logic [4:0]            rsp_rd;
  logic [31:0]           busy;

  regfile_operand_reader #(.WIDTH(64), .NREGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .reset(reset), .regs_in(regs_in), .wr_en(wr_en), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_ra(req_ra), .req_rb(req_rb),
    .req_rd(req_rd), .req_rd_we(req_rd_we), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_rd(rsp_rd), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: bank contents, outstanding-producer flags, buffered response.
  logic [63:0] bank [32];
  bit          sb [32];
  bit          m_v;
  logic [63:0] m_a, m_b;
  int          m_rd;

  // Stimulus for the next cycle.
  bit          s_rst, s_v, s_rdwe, s_rr, s_we;
  int          s_ra, s_rb, s_rd, s_wi;
  logic [63:0] s_wd;

  function automatic logic [63:0] pick(int idx);
    if (idx == 31) return 64'd0;
    if (s_we && s_wi == idx) return s_wd;
    return bank[idx];
  endfunction

  function automatic bit blocked(int r);
    return sb[r] && !(s_we && s_wi == r && r != 31);
  endfunction

  function automatic bit m_ready();
    return s_rst && !blocked(s_ra) && !blocked(s_rb) && !(s_rdwe && blocked(s_rd)) && (!m_v || s_rr);
  endfunction

  function automatic logic [31:0] sb_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = sb[i];
    return v;
  endfunction

  task automatic m_reset();
    m_v = 0; m_a = 0; m_b = 0; m_rd = 0;
    for (int i = 0; i < 32; i++) sb[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    bit acc;
    @(negedge clk);
    reset     = s_rst;
    req_valid = s_v;
    req_ra    = 5'(s_ra);
    req_rb    = 5'(s_rb);
    req_rd    = 5'(s_rd);
    req_rd_we = s_rdwe;
    rsp_ready = s_rr;
    wr_en     = s_we ? (32'd1 << s_wi) : 32'd0;
    wr_data   = s_wd;
    for (int i = 0; i < 32; i++) regs_in[i] = bank[i];
    #1;
    chk("req_ready", {63'd0, req_ready}, {63'd0, m_ready()});
    chk("busy_pre", {32'd0, busy}, {32'd0, sb_vec()});
    @(posedge clk);
    acc = s_v && m_ready();
    if (!s_rst) begin
      m_reset();
    end else begin
      if (acc) begin
        m_v = 1; m_a = pick(s_ra); m_b = pick(s_rb); m_rd = s_rd;
      end else if (s_rr) begin
        m_v = 0;
      end
      if (s_we && s_wi != 31) sb[s_wi] = 0;
      if (acc && s_rdwe && s_rd != 31) sb[s_rd] = 1;
    end
    if (s_we) bank[s_wi] = s_wd;
    #1;
    chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_v});
    chk("rsp_a", rsp_a, m_a);
    chk("rsp_b", rsp_b, m_b);
    chk("rsp_rd", {59'd0, rsp_rd}, 64'(m_rd));
    chk("busy", {32'd0, busy}, {32'd0, sb_vec()});
  endtask

  initial begin
    logic [63:0] held_a;
    int q[$];
    for (int i = 0; i < 32; i++) bank[i] = {$urandom, $urandom};
    m_reset();
    s_rst = 0; s_v = 0; s_rdwe = 0; s_rr = 1; s_we = 0;
    s_ra = 0; s_rb = 0; s_rd = 0; s_wi = 0; s_wd = 0;
    reset = 1'b1; req_valid = 0; req_ra = 0; req_rb = 0; req_rd = 0; req_rd_we = 0;
    rsp_ready = 1; wr_en = 0; wr_data = 0;
    for (int i = 0; i < 32; i++) regs_in[i] = bank[i];
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_a", rsp_a, 64'd0);
    chk("rst_busy", {32'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, req_ready}, 64'd0);
    s_v = 1; s_ra = 3; s_rb = 4;
    cyc(); cyc();

    // Basic read right after reset release.
    bank[3] = 64'h41; bank[4] = 64'h3F2;
    s_rst = 1; s_v = 1; s_ra = 3; s_rb = 4; s_rd = 1; s_rdwe = 0;
    cyc();
    chk("basic_valid", {63'd0, rsp_valid}, 64'd1);
    chk("basic_a", rsp_a, 64'h41);
    chk("basic_b", rsp_b, 64'h3F2);

    // Zero register reads 0 and is never marked busy.
    bank[31] = 64'hDEAD;
    s_ra = 31; s_rb = 31; s_rd = 31; s_rdwe = 1;
    cyc();
    chk("zero_a", rsp_a, 64'd0);
    chk("zero_b", rsp_b, 64'd0);
    chk("zero_busy", {32'd0, busy}, 64'd0);

    // Same-cycle bypass.
    bank[0] = 64'd5000;
    s_we = 1; s_wi = 0; s_wd = 64'd600; s_ra = 0; s_rb = 3; s_rd = 2; s_rdwe = 0;
    cyc();
    chk("bypass_a", rsp_a, 64'd600);
    s_we = 0;

    // RAW stall released by the producer's write pulse.
    s_ra = 1; s_rb = 2; s_rd = 30; s_rdwe = 1;
    cyc();
    chk("raw_busy_set", {63'd0, busy[30]}, 64'd1);
    s_ra = 30; s_rb = 3; s_rd = 5; s_rdwe = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("raw_stall_ready", {63'd0, req_ready}, 64'd0);
    end
    s_we = 1; s_wi = 30; s_wd = 64'h77;
    cyc();
    chk("raw_bypass_a", rsp_a, 64'h77);
    chk("raw_busy_clr", {63'd0, busy[30]}, 64'd0);
    s_we = 0;

    // Backpressure then back-to-back drain.
    s_rr = 0; s_ra = 3; s_rb = 4; s_rd = 9;
    held_a = m_a;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp_hold_a", rsp_a, held_a);
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
    end
    s_rr = 1;
    for (int i = 0; i < 3; i++) begin
      s_ra = 10 + i; s_rb = 4;
      cyc();
      chk("b2b_valid", {63'd0, rsp_valid}, 64'd1);
      chk("b2b_a", rsp_a, bank[10 + i]);
    end

    // Set/clear collision: new producer wins.
    s_ra = 1; s_rb = 2; s_rd = 7; s_rdwe = 1;
    cyc();
    s_we = 1; s_wi = 7; s_wd = 64'h1234;
    cyc();
    chk("collide_busy7", {63'd0, busy[7]}, 64'd1);
    s_we = 0; s_v = 0; s_rdwe = 0;

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("arst_busy", {32'd0, busy}, 64'd0);
    chk("arst_ready", {63'd0, req_ready}, 64'd0);
    m_reset();
    s_rst = 0;
    cyc();
    s_rst = 1;

    // Randomized traffic; writes favour busy registers so stalls resolve.
    for (int n = 0; n < 400; n++) begin
      s_v    = ($urandom % 4) != 0;
      s_ra   = $urandom % 32;
      s_rb   = ($urandom % 8 == 0) ? s_ra : int'($urandom % 32);
      s_rd   = $urandom % 32;
      s_rdwe = $urandom % 2;
      s_rr   = ($urandom % 4) != 0;
      s_we   = ($urandom % 3) != 0;
      s_wd   = {$urandom, $urandom};
      q.delete();
      for (int i = 0; i < 32; i++) if (sb[i]) q.push_back(i);
      if (q.size() > 0 && ($urandom % 2))
        s_wi = q[$urandom % q.size()];
      else
        s_wi = $urandom % 32;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
